// File: rtl/imager_pkg.sv
// rtl/imager_pkg.sv - shared state encoding, size defaults and helpers for the exposure sequencer
package imager_pkg;

    localparam int NUM_ROWS_DEF      = 160;
    localparam int WORDS_PER_ROW_DEF = 18;
    localparam int ROW_CLKS_DEF      = 24;
    localparam int ROW_AW_DEF        = 8;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_FIRST     = 5'b00010,
        ST_PATS_ROWS = 5'b00100,
        ST_PATS_EXP  = 5'b01000,
        ST_LAST      = 5'b10000
    } state_t;

    // A zero exposure request still opens the gate for one cycle.
    function automatic logic [31:0] exp_len(input logic [31:0] clks);
        return (clks == 32'd0) ? 32'd1 : clks;
    endfunction

endpackage

// File: rtl/row_engine.sv
// rtl/row_engine.sv - row slot timing, FIFO word reads with stall-on-empty, scene-done strobe
module row_engine #(
    parameter int NUM_ROWS      = 160,
    parameter int WORDS_PER_ROW = 18,
    parameter int ROW_CLKS      = 24,
    parameter int ROW_AW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              row_load,
    output logic [ROW_AW-1:0] row_addr,
    output logic              stall,
    output logic              scene_done
);

    localparam int SW = (ROW_CLKS > 1) ? $clog2(ROW_CLKS) : 1;

    logic [SW-1:0]     r_slot;
    logic [ROW_AW-1:0] r_row;
    logic              w_word_due;
    logic              w_slot_last;
    logic              w_row_last;

    // The word index equals the slot index: slots only advance once their word is taken.
    assign w_word_due  = active && (32'(r_slot) < 32'(WORDS_PER_ROW));
    assign stall       = w_word_due && fifo_empty;
    assign fifo_rd     = w_word_due && !fifo_empty;
    assign row_load    = fifo_rd;
    assign w_slot_last = (32'(r_slot) == 32'(ROW_CLKS - 1));
    assign w_row_last  = (32'(r_row) == 32'(NUM_ROWS - 1));
    assign scene_done  = active && !stall && w_slot_last && w_row_last;
    assign row_addr    = r_row;

    always_ff @(posedge clk) begin
        if (!rst || !active) begin
            r_slot <= '0;
            r_row  <= '0;
        end else if (!stall) begin
            if (w_slot_last) begin
                r_slot <= '0;
                r_row  <= w_row_last ? '0 : r_row + ROW_AW'(1);
            end else begin
                r_slot <= r_slot + SW'(1);
            end
        end
    end

endmodule

// File: rtl/exposure_seq.sv
// rtl/exposure_seq.sv - frame sequencer FSM, subscene/frame counters, stop handling; UNDERRUN_CNT_EN adds a stall counter
module exposure_seq
    import imager_pkg::*;
#(
    parameter int NUM_ROWS      = NUM_ROWS_DEF,
    parameter int WORDS_PER_ROW = WORDS_PER_ROW_DEF,
    parameter int ROW_CLKS      = ROW_CLKS_DEF,
    parameter int ROW_AW        = ROW_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       num_pat,
    input  logic [31:0]       num_frames,
    input  logic [31:0]       exp_clks,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              row_load,
    output logic [ROW_AW-1:0] row_addr,
    output logic              expose,
    output logic [31:0]       cnt_subc,
    output logic              frame_done,
    output logic              busy,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    state_t      r_state;
    logic [31:0] r_num_pat;
    logic [31:0] r_num_frames;
    logic [31:0] r_frames;
    logic [31:0] r_cnt_subc;
    logic [31:0] r_exp_left;
    logic        r_expose;
    logic        r_frame_done;
    logic        r_pend_stop;
    logic        r_underrun;

    logic        w_active;
    logic        w_stall;
    logic        w_scene_done;
    logic        w_stop_req;
    logic        w_start_ok;

    assign w_active   = (r_state == ST_FIRST) || (r_state == ST_PATS_ROWS) || (r_state == ST_LAST);
    assign w_stop_req = r_pend_stop || stop;
    assign w_start_ok = (r_state == ST_IDLE) && start && !stop;

    row_engine #(
        .NUM_ROWS      (NUM_ROWS),
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .ROW_CLKS      (ROW_CLKS),
        .ROW_AW        (ROW_AW)
    ) u_row_engine (
        .clk        (clk),
        .rst        (rst),
        .active     (w_active),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .row_load   (row_load),
        .row_addr   (row_addr),
        .stall      (w_stall),
        .scene_done (w_scene_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_num_pat    <= '0;
            r_num_frames <= '0;
            r_frames     <= '0;
            r_cnt_subc   <= '0;
            r_exp_left   <= '0;
            r_expose     <= 1'b0;
            r_frame_done <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_stall) r_underrun <= 1'b1;
            if (r_state == ST_IDLE) r_pend_stop <= 1'b0;
            else if (stop)          r_pend_stop <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state      <= ST_FIRST;
                        r_cnt_subc   <= '0;
                        r_frames     <= '0;
                        r_num_pat    <= num_pat;
                        r_num_frames <= num_frames;
                    end
                end
                ST_FIRST: begin
                    if (w_scene_done)
                        r_state <= (r_num_pat == 32'd0) ? ST_LAST : ST_PATS_ROWS;
                end
                ST_PATS_ROWS: begin
                    if (w_scene_done) begin
                        r_state    <= ST_PATS_EXP;
                        r_expose   <= 1'b1;
                        r_exp_left <= exp_len(exp_clks);
                    end
                end
                ST_PATS_EXP: begin
                    if (r_exp_left == 32'd1) begin
                        r_expose   <= 1'b0;
                        r_cnt_subc <= r_cnt_subc + 32'd1;
                        r_state    <= ((r_cnt_subc + 32'd1 < r_num_pat) && !w_stop_req)
                                      ? ST_PATS_ROWS : ST_LAST;
                    end else begin
                        r_exp_left <= r_exp_left - 32'd1;
                    end
                end
                ST_LAST: begin
                    if (w_scene_done) begin
                        r_frame_done <= 1'b1;
                        if (w_stop_req || ((r_num_frames != 32'd0) && (r_frames + 32'd1 == r_num_frames))) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_FIRST;
                            r_cnt_subc <= '0;
                            r_frames   <= r_frames + 32'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (!rst || w_start_ok)
            r_underrun_cnt <= '0;
        else if (w_stall && (r_underrun_cnt != 16'hFFFF))
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    assign underrun_cnt = 16'd0;
`endif

    assign expose     = r_expose;
    assign cnt_subc   = r_cnt_subc;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != ST_IDLE);
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_exposure_seq.sv
// tb/tb_exposure_seq.sv - self-checking bench for exposure_seq with a frame-level reference model
module tb_exposure_seq;

    localparam int NR  = 4;
    localparam int WPR = 2;
    localparam int RC  = 4;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [31:0]   num_pat = '0;
    logic [31:0]   num_frames = '0;
    logic [31:0]   exp_clks = '0;
    logic          fifo_empty = 1'b0;
    logic          fifo_rd;
    logic          row_load;
    logic [AW-1:0] row_addr;
    logic          expose;
    logic [31:0]   cnt_subc;
    logic          frame_done;
    logic          busy;
    logic          underrun;
    logic [15:0]   underrun_cnt;

    exposure_seq #(.NUM_ROWS(NR), .WORDS_PER_ROW(WPR), .ROW_CLKS(RC), .ROW_AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .num_pat(num_pat), .num_frames(num_frames), .exp_clks(exp_clks),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .row_load(row_load),
        .row_addr(row_addr), .expose(expose), .cnt_subc(cnt_subc),
        .frame_done(frame_done), .busy(busy), .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Activity observed at the falling edge
    int m_reads = 0, m_exp = 0, m_done = 0, m_busy = 0, run_len = 0;
    int m_runs[$];
    int m_rows[$];
    int b_reads, b_exp, b_done, b_busy, b_runs, b_rows;

    always @(negedge clk) begin
        if (rst) begin
            m_reads += int'(fifo_rd);
            m_exp   += int'(expose);
            m_done  += int'(frame_done);
            m_busy  += int'(busy);
            if (busy) m_rows.push_back(int'(row_addr));
            if (expose) run_len++;
            else if (run_len > 0) begin
                m_runs.push_back(run_len);
                run_len = 0;
            end
        end
    end

    // Frame-level model: scene counts and exposure lengths from the frame structure
    function automatic int eff_exp(input int e);
        return (e == 0) ? 1 : e;
    endfunction
    function automatic int model_reads(input int np, input int nf);
        return nf * (2 + np) * NR * WPR;
    endfunction
    function automatic int model_busy(input int np, input int nf, input int e);
        return nf * ((2 + np) * NR * RC + np * eff_exp(e));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_reads = m_reads; b_exp = m_exp; b_done = m_done; b_busy = m_busy;
        b_runs = m_runs.size(); b_rows = m_rows.size();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic run_seq(input int np, input int nf, input int e, input bit noise,
                           input int stop_at, input int empty_from, input int empty_len,
                           output bit timed_out);
        int k;
        num_pat = 32'(np); num_frames = 32'(nf); exp_clks = 32'(e);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        timed_out = 1'b0;
        forever begin
            stop = (k == stop_at);
            fifo_empty = (k >= empty_from && k < empty_from + empty_len) ||
                         (noise && ($urandom_range(0, 3) == 0));
            step();
            k++;
            if (busy !== 1'b1) break;
            if (k > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
        stop = 1'b0;
        fifo_empty = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, expose, fifo_rd, row_load, frame_done, underrun} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000", {busy, expose, fifo_rd, row_load, frame_done, underrun});
        end
        checks++;
        if (row_addr !== '0 || cnt_subc !== 32'd0 || underrun_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counts: got row %0d subc %0d ucnt %0d expected 0", row_addr, cnt_subc, underrun_cnt);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_frame(input int np, input int e, input string tag);
        bit to;
        int bad;
        snap();
        run_seq(np, 1, e, 1'b0, -1, -1, 0, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout: got busy stuck expected idle", tag); end
        checks++;
        if (m_reads - b_reads !== model_reads(np, 1)) begin
            errors++; $display("FAIL %s_reads: got %0d expected %0d", tag, m_reads - b_reads, model_reads(np, 1));
        end
        checks++;
        if (m_busy - b_busy !== model_busy(np, 1, e)) begin
            errors++; $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, m_busy - b_busy, model_busy(np, 1, e));
        end
        checks++;
        if (m_runs.size() - b_runs !== np) begin
            errors++; $display("FAIL %s_expose_runs: got %0d expected %0d", tag, m_runs.size() - b_runs, np);
        end
        bad = 0;
        for (int i = b_runs; i < m_runs.size(); i++) if (m_runs[i] != eff_exp(e)) bad++;
        checks++;
        if (bad != 0 || m_exp - b_exp !== np * eff_exp(e)) begin
            errors++; $display("FAIL %s_expose_len: got %0d cycles expected %0d", tag, m_exp - b_exp, np * eff_exp(e));
        end
        checks++;
        if (m_done - b_done !== 1) begin
            errors++; $display("FAIL %s_frame_done: got %0d expected 1", tag, m_done - b_done);
        end
        checks++;
        if (cnt_subc !== 32'(np) || busy !== 1'b0) begin
            errors++; $display("FAIL %s_end_state: got subc %0d busy %b expected %0d 0", tag, cnt_subc, busy, np);
        end
    endtask

    task automatic test_underrun();
        bit to;
        int bad;
        int exp_ucnt;
`ifdef UNDERRUN_CNT_EN
        exp_ucnt = 6;
`else
        exp_ucnt = 0;
`endif
        do_reset();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre: got %b expected 0", underrun); end
        snap();
        // FIRST scene: row 2 occupies cycles 8..11; its second word is due at cycle 9.
        run_seq(2, 1, 3, 1'b0, -1, 9, 6, to);
        checks++;
        if (to) begin errors++; $display("FAIL underrun_timeout: got busy stuck expected idle"); end
        bad = 0;
        if (m_rows.size() < b_rows + 19) bad = 99;
        else begin
            if (m_rows[b_rows + 7] != 1) bad++;
            for (int k = 8; k <= 17; k++) if (m_rows[b_rows + k] != 2) bad++;
            if (m_rows[b_rows + 18] != 3) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL underrun_row_freeze: got %0d bad row samples expected 0", bad); end
        checks++;
        if (m_reads - b_reads !== 32) begin
            errors++; $display("FAIL underrun_reads: got %0d expected 32", m_reads - b_reads);
        end
        checks++;
        if (m_busy - b_busy !== model_busy(2, 1, 3) + 6) begin
            errors++; $display("FAIL underrun_busy: got %0d expected %0d", m_busy - b_busy, model_busy(2, 1, 3) + 6);
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
        checks++;
        if (underrun_cnt !== 16'(exp_ucnt)) begin
            errors++; $display("FAIL underrun_cnt: got %0d expected %0d", underrun_cnt, exp_ucnt);
        end
    endtask

    task automatic test_stop();
        bit to;
        snap();
        // FIRST 0..15, rows 16..31, exp 32..33, second rows 34..49
        run_seq(5, 0, 2, 1'b0, 40, -1, 0, to);
        checks++;
        if (to) begin errors++; $display("FAIL stop_timeout: got busy stuck expected idle"); end
        checks++;
        if (m_runs.size() - b_runs !== 2 || cnt_subc !== 32'd2) begin
            errors++; $display("FAIL stop_subscenes: got runs %0d subc %0d expected 2 2", m_runs.size() - b_runs, cnt_subc);
        end
        checks++;
        if (m_done - b_done !== 1 || m_reads - b_reads !== 32) begin
            errors++; $display("FAIL stop_frame: got done %0d reads %0d expected 1 32", m_done - b_done, m_reads - b_reads);
        end
        checks++;
        if (m_busy - b_busy !== 68) begin
            errors++; $display("FAIL stop_busy: got %0d expected 68", m_busy - b_busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        num_pat = 32'd2; num_frames = 32'd1; exp_clks = 32'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (expose !== 1'b1 && n < 200) begin step(); n++; end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rstmid_reach_exp: got no expose expected expose"); end
        rst = 1'b0;
        step();
        checks++;
        if ({busy, expose, fifo_rd, row_load, frame_done} !== 5'b0 || cnt_subc !== 32'd0 || row_addr !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got busy %b exp %b subc %0d row %0d expected zeros", busy, expose, cnt_subc, row_addr);
        end
        rst = 1'b1;
        step();
        test_single_frame(2, 4, "rstmid_clean");
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: got %b expected 0 at cycle %0d", busy, i); end
            step();
        end
    endtask

    task automatic test_random();
        bit to;
        int np, nf, e;
        bit noise;
        for (int it = 0; it < 6; it++) begin
            np = $urandom_range(0, 3);
            nf = $urandom_range(1, 2);
            e  = $urandom_range(0, 4);
            noise = it[0];
            snap();
            run_seq(np, nf, e, noise, -1, -1, 0, to);
            checks++;
            if (to || m_done - b_done !== nf) begin
                errors++; $display("FAIL rand%0d_frames: got %0d timeout %b expected %0d", it, m_done - b_done, to, nf);
            end
            checks++;
            if (m_reads - b_reads !== model_reads(np, nf)) begin
                errors++; $display("FAIL rand%0d_reads: got %0d expected %0d", it, m_reads - b_reads, model_reads(np, nf));
            end
            checks++;
            if (m_exp - b_exp !== nf * np * eff_exp(e) || cnt_subc !== 32'(np)) begin
                errors++; $display("FAIL rand%0d_expose: got %0d subc %0d expected %0d %0d", it, m_exp - b_exp, cnt_subc, nf * np * eff_exp(e), np);
            end
            if (!noise) begin
                checks++;
                if (m_busy - b_busy !== model_busy(np, nf, e)) begin
                    errors++; $display("FAIL rand%0d_busy: got %0d expected %0d", it, m_busy - b_busy, model_busy(np, nf, e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(2, 3, "single");
        test_single_frame(0, 5, "nopat");
        test_single_frame(3, 0, "exp_zero");
        test_underrun();
        test_stop();
        test_reset_mid();
        test_start_stop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exposure_seq.md
Name: exposure_seq

Overview:
- Frame-level sequencer for the coded-exposure imager.
- Consumes the pattern FIFO filled by the pattern generator and produces per-row load timing and exposure gating.
- Maintains the subscene counter that the pattern generator and host use.
- Frame structure: one unexposed first scene, then num_pat exposed subscenes, then one unexposed last scene; repeats for num_frames frames.

Parameters:
- NUM_ROWS, 160, pixel rows per scene.
- WORDS_PER_ROW, 18, FIFO words consumed per row.
- ROW_CLKS, 24, clocks per row slot; must be >= WORDS_PER_ROW.
- ROW_AW, 8, row address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle host trigger.
- stop  in  1  one-cycle host abort request.
- num_pat  in  32  exposed subscenes per frame.
- num_frames  in  32  frames to run; 0 means free-run until stop.
- exp_clks  in  32  exposure cycles per subscene; 0 is treated as 1.
- fifo_empty  in  1  pattern FIFO empty.
- fifo_rd  out  1  pattern FIFO read enable.
- row_load  out  1  high while the current row's words are being shifted.
- row_addr  out  ROW_AW  current row.
- expose  out  1  pixel exposure gate.
- cnt_subc  out  32  completed exposed subscenes in the current frame.
- frame_done  out  1  one-cycle pulse at end of each frame.
- busy  out  1  high whenever not IDLE.
- underrun  out  1  sticky; set when a required read finds the FIFO empty.
- underrun_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE; every output 0; all counters 0. A reset mid-frame aborts immediately, with no partial last scene.
- States: IDLE, FIRST, PATS_ROWS, PATS_EXP, LAST.
- IDLE:
  - start=1 and stop=0 -> FIRST, with cnt_subc<=0 and the frame counter <=0.
  - start and stop together -> remain IDLE.
  - start while busy is ignored.
- Row engine (FIRST, PATS_ROWS, LAST):
  - Row slot of ROW_CLKS cycles; word counter w counts 0..WORDS_PER_ROW-1.
  - fifo_rd = row_load = 1 while w < WORDS_PER_ROW and fifo_empty=0.
  - If fifo_empty=1 when a word is due: fifo_rd=0, set underrun, and freeze the slot counter until data arrives (stall, no skip).
  - Slot ends after ROW_CLKS cycles; row_addr then increments.
  - After row NUM_ROWS-1, row_addr wraps to 0 and the scene ends.
  - Words consumed per scene is exactly NUM_ROWS*WORDS_PER_ROW.
- FIRST end:
  - num_pat=0 -> LAST.
  - Otherwise -> PATS_ROWS.
- PATS_ROWS end -> PATS_EXP.
- PATS_EXP:
  - expose=1 for max(exp_clks,1) cycles; the first cycle is registered at entry, so latency from scene end is 1 clock.
  - On exit cnt_subc<=cnt_subc+1.
  - If cnt_subc+1 < num_pat and no pending stop -> PATS_ROWS; else -> LAST.
- LAST end:
  - frame_done pulses for 1 cycle.
  - If pending stop, or num_frames≠0 and frames_done+1 = num_frames -> IDLE.
  - Otherwise -> FIRST, cnt_subc<=0.
- stop handling:
  - In a busy state, stop sets pending_stop.
  - The current scene finishes; a pending stop in PATS_* proceeds to LAST after the current subscene's exposure.
  - pending_stop clears in IDLE.
- expose is 0 in all states other than PATS_EXP.
- cnt_subc is held through LAST and is visible to the pattern generator for its continue/stop decision.
- Arithmetic:
  - 32-bit unsigned compares.
  - num_pat and num_frames are sampled into registers at start; later changes take effect at the next start.
  - exp_clks is sampled at each PATS_EXP entry.

Optional Feature:
- Macro UNDERRUN_CNT_EN.
- When defined: underrun_cnt increments once per stalled cycle, saturating at 16'hFFFF, and clears at start.
- When undefined: underrun_cnt tied to 0, no counter logic; the sticky underrun bit exists in both builds.

Decomposition:
- Shared package imager_pkg: state encoding constants (one-hot, 5 bits), NUM_ROWS/WORDS_PER_ROW defaults, ROW_AW.
- One sub-module, row_engine: row/word/slot counters, stall logic and the scene-done pulse. The top holds the FSM, subscene/frame counters and stop logic.

Test Plan:
- Bench overrides NUM_ROWS=4, WORDS_PER_ROW=2, ROW_CLKS=4; FIFO is never empty unless stated.
- Single frame: num_pat=2, exp_clks=3, num_frames=1, pulse start.
  - Required: 32 fifo_rd cycles total (4 scenes × 8); expose high in exactly 2 runs of 3 cycles; cnt_subc reaches 2; one frame_done; busy drops the cycle after.
- num_pat=0, exp_clks=5.
  - Required: FIRST then LAST only; expose never high; 16 reads; frame_done once.
- Underrun: deassert FIFO data for 6 cycles mid-row 2 of FIRST.
  - Required: row_addr frozen 6 cycles; underrun=1 sticky; total reads still 32; with UNDERRUN_CNT_EN, underrun_cnt=6.
- Stop: num_frames=0, num_pat=5; pulse stop during the 2nd PATS_ROWS.
  - Required: exposure 2 completes; cnt_subc=2; LAST runs; frame_done pulses; IDLE.
- Reset: drive rst=0 for 1 cycle during PATS_EXP.
  - Required: next cycle all outputs 0, state IDLE; a subsequent start runs a clean frame.
- Start and stop in the same IDLE cycle.
  - Required: busy stays 0.
- exp_clks=0.
  - Required: 1-cycle expose pulse per subscene.
